// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, NOP encoding, register-address width,
// and the immediate-extension rule used by the decode stage.
package mips_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // Logical immediates are zero-extended; every other opcode sign-extends.
  function automatic logic [31:0] imm_ext(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
      imm_ext = {16'h0000, ins[15:0]};
    else
      imm_ext = {{16{ins[15]}}, ins[15:0]};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch/EX/WB-facing signal bundle of the decode stage; master drives inputs
// to the stage, slave is the stage itself.
interface id_stage_if;
  import mips_pkg::*;

  logic [31:0]       Ins;
  logic [31:0]       nextPC;
  logic              flush;
  logic              ex_memread;
  logic [REG_AW-1:0] ex_rt;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [31:0]       wb_data;

  logic              stall;
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [5:0]        id_opcode;
  logic [5:0]        id_funct;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [31:0]       id_rs_data;
  logic [31:0]       id_rt_data;
  logic [31:0]       id_imm;
  logic [31:0]       id_br_target;

  modport master (
    output Ins, nextPC, flush, ex_memread, ex_rt, wb_we, wb_addr, wb_data,
    input  stall, id_valid, id_pc, id_opcode, id_funct, id_rs, id_rt, id_rd,
           id_rs_data, id_rt_data, id_imm, id_br_target
  );

  modport slave (
    input  Ins, nextPC, flush, ex_memread, ex_rt, wb_we, wb_addr, wb_data,
    output stall, id_valid, id_pc, id_opcode, id_funct, id_rs, id_rt, id_rd,
           id_rs_data, id_rt_data, id_imm, id_br_target
  );

endinterface

// File: rtl/id_regfile.sv
// 32x32 register file, 2 combinational read ports, 1 write port, r0 hardwired 0.
// ID_WB_BYPASS_EN: same-cycle write data is forwarded to a matching read.
module id_regfile
  import mips_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [31:0]       rd1,
  output logic [31:0]       rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [31:0]       wd
);

  logic [31:0] regs [32];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  function automatic logic [31:0] rd_port(input logic [REG_AW-1:0] ra);
    if (ra == '0)
      rd_port = 32'h0;
`ifdef ID_WB_BYPASS_EN
    else if (we && wa == ra)
      rd_port = wd;
`endif
    else
      rd_port = regs[ra];
  endfunction

  assign rd1 = rd_port(ra1);
  assign rd2 = rd_port(ra2);

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID latch (1-cycle latency), field decode, regfile read,
// load-use stall; flush beats stall. ID_WB_BYPASS_EN selects regfile WB forwarding.
module id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INS  = MIPS_NOP,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
  input logic     CLK,
  input logic     RST,
  id_stage_if.slave bus
);

  logic [31:0]       ins_q;
  logic [31:0]       pc_q;
  logic              valid_q;
  logic              stall_w;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [31:0]       imm;

  always_ff @(posedge CLK) begin
    if (RST || bus.flush) begin
      ins_q   <= NOP_INS;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else if (!stall_w) begin
      ins_q   <= bus.Ins;
      pc_q    <= bus.nextPC;
      valid_q <= 1'b1;
    end
  end

  assign rs  = ins_q[25:21];
  assign rt  = ins_q[20:16];
  assign imm = imm_ext(ins_q);

  // Load-use hazard: the load in EX targets a source of the instruction held here.
  assign stall_w = valid_q && bus.ex_memread && (bus.ex_rt != '0) &&
                   ((bus.ex_rt == rs) || (bus.ex_rt == rt));

  assign bus.stall        = stall_w;
  assign bus.id_valid     = valid_q;
  assign bus.id_pc        = pc_q;
  assign bus.id_opcode    = ins_q[31:26];
  assign bus.id_rs        = rs;
  assign bus.id_rt        = rt;
  assign bus.id_rd        = ins_q[15:11];
  assign bus.id_funct     = ins_q[5:0];
  assign bus.id_imm       = imm;
  assign bus.id_br_target = pc_q + (imm << 2);

  id_regfile u_regfile (
    .CLK (CLK),
    .RST (RST),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (bus.id_rs_data),
    .rd2 (bus.id_rt_data),
    .we  (bus.wb_we),
    .wa  (bus.wb_addr),
    .wd  (bus.wb_data)
  );

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: table-driven decode vectors, hand sequences for stall/flush/
// reset/write-read corners, then randomized traffic against a behavioural model.
module tb_id_stage;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  id_stage_if ifc ();

  id_stage dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc)
  );

  int checks = 0;
  int errors = 0;

`ifdef ID_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.Ins = 32'h0; ifc.nextPC = 32'h0; ifc.flush = 1'b0;
    ifc.ex_memread = 1'b0; ifc.ex_rt = 5'd0;
    ifc.wb_we = 1'b0; ifc.wb_addr = 5'd0; ifc.wb_data = 32'h0;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] npc;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  fn;
    logic [31:0] imm;
    logic [31:0] br;
  } vec_t;

  vec_t tbl [8];

  // Behavioural reference state.
  logic [31:0] m_ins, m_pc;
  logic        m_valid;
  logic [31:0] m_regs [32];

  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    logic [31:0] op, lo;
    op = ins >> 26;
    lo = ins & 32'h0000_FFFF;
    if (op == 12 || op == 13 || op == 14) return lo;
    return (lo >= 32768) ? (lo | 32'hFFFF_0000) : lo;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (BYPASS && ifc.wb_we && ifc.wb_addr == r) return ifc.wb_data;
    return m_regs[r];
  endfunction

  initial begin
    logic [4:0]  ers, ert;
    logic [31:0] eimm;
    logic        estall;

    tbl[0] = '{32'h2008_0005, 32'h0000_0004, 6'h08, 5'd0, 5'd8,  5'd0,  6'h05, 32'h0000_0005, 32'h0000_0018};
    tbl[1] = '{32'h3508_FFFF, 32'h0000_0008, 6'h0D, 5'd8, 5'd8,  5'd31, 6'h3F, 32'h0000_FFFF, 32'h0004_0004};
    tbl[2] = '{32'h2108_FFFF, 32'h0000_000C, 6'h08, 5'd8, 5'd8,  5'd31, 6'h3F, 32'hFFFF_FFFF, 32'h0000_0008};
    tbl[3] = '{32'h1000_0001, 32'hFFFF_FFFC, 6'h04, 5'd0, 5'd0,  5'd0,  6'h01, 32'h0000_0001, 32'h0000_0000};
    tbl[4] = '{32'h3000_8000, 32'h0000_0100, 6'h0C, 5'd0, 5'd0,  5'd16, 6'h00, 32'h0000_8000, 32'h0002_0100};
    tbl[5] = '{32'h3800_8000, 32'h0000_0200, 6'h0E, 5'd0, 5'd0,  5'd16, 6'h00, 32'h0000_8000, 32'h0002_0200};
    tbl[6] = '{32'h8C00_8000, 32'h0000_0010, 6'h23, 5'd0, 5'd0,  5'd16, 6'h00, 32'hFFFF_8000, 32'hFFFE_0010};
    tbl[7] = '{32'h012A_5820, 32'h0000_0020, 6'h00, 5'd9, 5'd10, 5'd11, 6'h20, 32'h0000_5820, 32'h0001_60A0};

    // Reset state.
    idle_inputs();
    RST = 1'b1;
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_valid",  {31'd0, ifc.id_valid}, 32'h0);
    chk("rst_pc",     ifc.id_pc,             32'h0);
    chk("rst_opcode", {26'd0, ifc.id_opcode}, 32'h0);
    chk("rst_imm",    ifc.id_imm,            32'h0);
    chk("rst_br",     ifc.id_br_target,      32'h0);
    chk("rst_rsdata", ifc.id_rs_data,        32'h0);
    chk("rst_stall",  {31'd0, ifc.stall},    32'h0);

    // Decode table: each instruction appears one cycle after presentation.
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      ifc.Ins = tbl[i].ins;
      ifc.nextPC = tbl[i].npc;
      step();
      @(negedge CLK);
      chk($sformatf("tbl%0d_valid", i), {31'd0, ifc.id_valid}, 32'h1);
      chk($sformatf("tbl%0d_pc", i),    ifc.id_pc,              tbl[i].npc);
      chk($sformatf("tbl%0d_op", i),    {26'd0, ifc.id_opcode}, {26'd0, tbl[i].op});
      chk($sformatf("tbl%0d_rs", i),    {27'd0, ifc.id_rs},     {27'd0, tbl[i].rs});
      chk($sformatf("tbl%0d_rt", i),    {27'd0, ifc.id_rt},     {27'd0, tbl[i].rt});
      chk($sformatf("tbl%0d_rd", i),    {27'd0, ifc.id_rd},     {27'd0, tbl[i].rd});
      chk($sformatf("tbl%0d_fn", i),    {26'd0, ifc.id_funct},  {26'd0, tbl[i].fn});
      chk($sformatf("tbl%0d_imm", i),   ifc.id_imm,             tbl[i].imm);
      chk($sformatf("tbl%0d_br", i),    ifc.id_br_target,       tbl[i].br);
    end

    // Load-use stall on rs, hold, and non-stalling variants.
    @(posedge CLK); #1;
    ifc.Ins = 32'h0120_0000; ifc.nextPC = 32'h40;
    step();
    ifc.ex_memread = 1'b1; ifc.ex_rt = 5'd9;
    ifc.Ins = 32'h2008_0005; ifc.nextPC = 32'h44;
    @(negedge CLK);
    chk("lu_stall_rs", {31'd0, ifc.stall}, 32'h1);
    step();
    @(negedge CLK);
    chk("lu_hold_pc", ifc.id_pc, 32'h40);
    chk("lu_hold_rs", {27'd0, ifc.id_rs}, 32'd9);
    ifc.ex_rt = 5'd0;
    #1;
    chk("lu_rt0_nostall", {31'd0, ifc.stall}, 32'h0);
    ifc.ex_rt = 5'd9; ifc.ex_memread = 1'b0;
    #1;
    chk("lu_nomem_nostall", {31'd0, ifc.stall}, 32'h0);

    // Stall on rt match, then flush during the stall.
    @(posedge CLK); #1;
    ifc.Ins = 32'h0009_0000; ifc.nextPC = 32'h80;
    step();
    ifc.ex_memread = 1'b1; ifc.ex_rt = 5'd9;
    @(negedge CLK);
    chk("lu_stall_rt", {31'd0, ifc.stall}, 32'h1);
    ifc.flush = 1'b1; ifc.Ins = 32'h2008_0005; ifc.nextPC = 32'h84;
    step();
    ifc.flush = 1'b0;
    @(negedge CLK);
    chk("flush_valid", {31'd0, ifc.id_valid}, 32'h0);
    chk("flush_pc",    ifc.id_pc,             32'h0);
    chk("flush_rt",    {27'd0, ifc.id_rt},    32'h0);
    chk("flush_imm",   ifc.id_imm,            32'h0);
    ifc.ex_memread = 1'b0; ifc.ex_rt = 5'd0;

    // Same-cycle write/read of r5, then r0 write.
    @(posedge CLK); #1;
    ifc.wb_we = 1'b1; ifc.wb_addr = 5'd5; ifc.wb_data = 32'h1111_1111;
    ifc.Ins = 32'h00A0_0000; ifc.nextPC = 32'h100;
    step();
    ifc.wb_data = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("wr_same_cycle", ifc.id_rs_data, BYPASS ? 32'hDEAD_BEEF : 32'h1111_1111);
    step();
    ifc.wb_we = 1'b0;
    @(negedge CLK);
    chk("wr_next_cycle", ifc.id_rs_data, 32'hDEAD_BEEF);
    @(posedge CLK); #1;
    ifc.Ins = 32'h0000_0000;
    ifc.wb_we = 1'b1; ifc.wb_addr = 5'd0; ifc.wb_data = 32'hFFFF_FFFF;
    step();
    @(negedge CLK);
    chk("r0_same_cycle", ifc.id_rs_data, 32'h0);
    step();
    ifc.wb_we = 1'b0;
    @(negedge CLK);
    chk("r0_next_cycle", ifc.id_rs_data, 32'h0);

    // Reset during a stall discards the pending write and clears the regfile.
    @(posedge CLK); #1;
    ifc.Ins = 32'h00A9_0000; ifc.nextPC = 32'h200;
    step();
    ifc.ex_memread = 1'b1; ifc.ex_rt = 5'd5;
    @(negedge CLK);
    chk("rst_mid_stall_pre", {31'd0, ifc.stall}, 32'h1);
    ifc.wb_we = 1'b1; ifc.wb_addr = 5'd9; ifc.wb_data = 32'h1234_5678;
    RST = 1'b1;
    step();
    RST = 1'b0; ifc.wb_we = 1'b0; ifc.ex_memread = 1'b0; ifc.ex_rt = 5'd0;
    @(negedge CLK);
    chk("rst_mid_valid", {31'd0, ifc.id_valid}, 32'h0);
    @(posedge CLK); #1;
    step();
    @(negedge CLK);
    chk("rst_mid_r5", ifc.id_rs_data, 32'h0);
    chk("rst_mid_r9", ifc.id_rt_data, 32'h0);

    // Randomized traffic against the reference model.
    @(posedge CLK); #1;
    idle_inputs();
    RST = 1'b1;
    step();
    RST = 1'b0;
    m_ins = 32'h0; m_pc = 32'h0; m_valid = 1'b0;
    for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;

    for (int n = 0; n < 2000; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      ifc.Ins        = ins;
      ifc.nextPC     = $urandom;
      ifc.flush      = ($urandom_range(0, 7) == 0);
      ifc.ex_memread = ($urandom_range(0, 2) == 0);
      ifc.ex_rt      = 5'($urandom_range(0, 7));
      ifc.wb_we      = $urandom_range(0, 1) == 1;
      ifc.wb_addr    = 5'($urandom_range(0, 7));
      ifc.wb_data    = $urandom;
      RST            = ($urandom_range(0, 63) == 0);

      @(negedge CLK);
      ers    = 5'((m_ins >> 21) & 31);
      ert    = 5'((m_ins >> 16) & 31);
      eimm   = m_imm(m_ins);
      estall = m_valid && ifc.ex_memread && ifc.ex_rt != 0 &&
               (ifc.ex_rt == ers || ifc.ex_rt == ert);
      chk("rnd_valid",  {31'd0, ifc.id_valid}, {31'd0, m_valid});
      chk("rnd_pc",     ifc.id_pc,             m_pc);
      chk("rnd_op",     {26'd0, ifc.id_opcode}, m_ins >> 26);
      chk("rnd_rd",     {27'd0, ifc.id_rd},    (m_ins >> 11) & 31);
      chk("rnd_fn",     {26'd0, ifc.id_funct}, m_ins & 63);
      chk("rnd_imm",    ifc.id_imm,            eimm);
      chk("rnd_br",     ifc.id_br_target,      m_pc + eimm * 4);
      chk("rnd_stall",  {31'd0, ifc.stall},    {31'd0, estall});
      chk("rnd_rsdata", ifc.id_rs_data,        m_read(ers));
      chk("rnd_rtdata", ifc.id_rt_data,        m_read(ert));

      if (RST) begin
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
      end else if (ifc.wb_we && ifc.wb_addr != 0) begin
        m_regs[ifc.wb_addr] = ifc.wb_data;
      end
      if (RST || ifc.flush) begin
        m_ins = 32'h0; m_pc = 32'h0; m_valid = 1'b0;
      end else if (!estall) begin
        m_ins = ifc.Ins; m_pc = ifc.nextPC; m_valid = 1'b1;
      end
      step();
    end

    RST = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
